// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands one cipher key into 11 round keys, one round
// every two cycles through a single shared 4-byte S-box, and serves registered round-key reads.
module aes_key_sched_ctrl #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*Nk-1:0]     key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic                 busy,
    output logic                 keys_valid,
    input  logic                 rk_req,
    input  logic [3:0]           rk_idx,
    output logic                 rk_valid,
    output logic [32*Nk-1:0]     rk_out,
    output logic                 rk_err
);

    localparam int unsigned KeyW  = 32 * Nk;
    localparam int unsigned NKeys = Nr + 1;
    localparam int unsigned NWords = 1;

    // Forward AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SboxTab = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StSub, StMix, StDone} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTab[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        c = 8'h00;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    state_e            state_q;
    logic [3:0]        round_q;
    logic [KeyW-1:0]   prev_q;      // rk[r-1], kept locally to avoid a wide read mux
    logic              busy_q;
    logic              key_ready_q;
    logic              keys_valid_q;
    logic              rk_valid_q;
    logic              rk_err_q;
    logic [KeyW-1:0]   rk_out_q;
    logic [KeyW-1:0]   rk_mem [NKeys];

    logic [32*NWords-1:0] sub_in;
    logic [32*NWords-1:0] sub_out;
    logic [31:0]          t_word;
    logic [31:0]          w0, w1, w2, w3;
    logic [KeyW-1:0]      next_key;
    logic                 accept;

    assign accept = key_valid && key_ready_q;

    // RotWord of the last word of rk[r-1]; prev_q is static across SUB and MIX, so the
    // S-box input stays stable until MIX samples the result.
    always_comb begin
        sub_in = {prev_q[23:0], prev_q[31:24]};
        for (int i = 0; i < 4 * NWords; i++) begin
            sub_out[8*i +: 8] = sbox(sub_in[8*i +: 8]);
        end
    end

    // Next round key from the S-box result and the previous round key.
    always_comb begin
        t_word   = sub_out ^ {rcon(round_q), 24'h0};
        w0       = prev_q[127:96] ^ t_word;
        w1       = prev_q[95:64]  ^ w0;
        w2       = prev_q[63:32]  ^ w1;
        w3       = prev_q[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    // Expansion FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            round_q      <= 4'd0;
            prev_q       <= '0;
            busy_q       <= 1'b0;
            key_ready_q  <= 1'b1;
            keys_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (key_valid) begin
                        prev_q       <= key_in;
                        round_q      <= 4'd1;
                        keys_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        key_ready_q  <= 1'b0;
                        state_q      <= StSub;
                    end
                end
                StSub: begin
                    state_q <= StMix;
                end
                StMix: begin
                    prev_q <= next_key;
                    if (round_q == 4'(Nr)) begin
                        keys_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        key_ready_q  <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        round_q <= round_q + 4'd1;
                        state_q <= StSub;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Round-key storage; not cleared by reset, writes suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                rk_mem[0] <= key_in;
            end
            if (state_q == StMix) begin
                rk_mem[round_q] <= next_key;
            end
        end
    end

    // Registered read port; uses keys_valid before any same-edge key acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_out_q   <= '0;
        end else if (rk_req) begin
            if (keys_valid_q && (rk_idx <= 4'(Nr))) begin
                rk_valid_q <= 1'b1;
                rk_err_q   <= 1'b0;
                rk_out_q   <= rk_mem[rk_idx];
            end else begin
                rk_valid_q <= 1'b0;
                rk_err_q   <= 1'b1;
            end
        end else begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign rk_valid   = rk_valid_q;
    assign rk_err     = rk_err_q;
    assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 and all-zero key expansions.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic         rk_err;

    int n_total;
    int n_bad;
    logic [127:0] exp_out;

    logic [127:0] fips_rk [11];
    logic [127:0] zero_rk1;
    logic [127:0] zero_rk10;

    aes_key_sched_ctrl #(.Nk(4), .Nr(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_out     (rk_out),
        .rk_err     (rk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_ok(input logic [3:0] idx, input logic [127:0] exp);
        rk_req = 1'b1;
        rk_idx = idx;
        step();
        rk_req = 1'b0;
        chk($sformatf("rd%0d_valid", idx), {127'd0, rk_valid}, 128'd1);
        chk($sformatf("rd%0d_err", idx), {127'd0, rk_err}, 128'd0);
        chk($sformatf("rd%0d_out", idx), rk_out, exp);
        exp_out = exp;
    endtask

    task automatic rd_bad(input string tag, input logic [3:0] idx);
        rk_req = 1'b1;
        rk_idx = idx;
        step();
        rk_req = 1'b0;
        chk({tag, "_valid"}, {127'd0, rk_valid}, 128'd0);
        chk({tag, "_err"}, {127'd0, rk_err}, 128'd1);
        chk({tag, "_out"}, rk_out, exp_out);
    endtask

    // Accepts a key and walks the 20-cycle expansion; optional stray key_valid pulses at
    // cycles 5 and 12 and a rejected read at cycle 3.
    task automatic load_key(input logic [127:0] key, input bit pulses, input bit rd_mid);
        key_in    = key;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk("acc_busy", {127'd0, busy}, 128'd1);
        chk("acc_ready", {127'd0, key_ready}, 128'd0);
        chk("acc_kv", {127'd0, keys_valid}, 128'd0);
        for (int c = 1; c <= 20; c++) begin
            if (pulses && (c == 5 || c == 12)) begin
                key_valid = 1'b1;
                key_in    = 128'hdeadbeef_00112233_44556677_8899aabb;
            end
            if (rd_mid && c == 3) begin
                rk_req = 1'b1;
                rk_idx = 4'd1;
            end
            step();
            key_valid = 1'b0;
            key_in    = key;
            if (rd_mid && c == 3) begin
                rk_req = 1'b0;
                chk("mid_valid", {127'd0, rk_valid}, 128'd0);
                chk("mid_err", {127'd0, rk_err}, 128'd1);
                chk("mid_out", rk_out, exp_out);
            end
            if (c == 19) chk("kv_c19", {127'd0, keys_valid}, 128'd0);
        end
        chk("kv_c20", {127'd0, keys_valid}, 128'd1);
        chk("done_busy", {127'd0, busy}, 128'd0);
        chk("done_ready", {127'd0, key_ready}, 128'd1);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_rk1    = 128'h62636363626363636263636362636363;
        zero_rk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = 4'd0;
        exp_out   = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_kv", {127'd0, keys_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_ready", {127'd0, key_ready}, 128'd1);
        chk("rst_rkv", {127'd0, rk_valid}, 128'd0);
        chk("rst_err", {127'd0, rk_err}, 128'd0);
        chk("rst_out", rk_out, 128'd0);

        // Read before any key is loaded.
        rd_bad("nokey", 4'd0);

        // Plain FIPS-197 load and full readback.
        load_key(fips_rk[0], 1'b0, 1'b0);
        for (int i = 0; i <= 10; i++) rd_ok(4'(i), fips_rk[i]);
        rd_bad("idx11", 4'd11);
        rd_bad("idx15", 4'd15);
        step();
        chk("idle_rkv", {127'd0, rk_valid}, 128'd0);
        chk("idle_err", {127'd0, rk_err}, 128'd0);
        chk("idle_out", rk_out, exp_out);

        // Reload from DONE with stray key_valid pulses and a read during expansion.
        load_key(fips_rk[0], 1'b1, 1'b1);
        rd_ok(4'd1, fips_rk[1]);
        rd_ok(4'd7, fips_rk[7]);
        rd_ok(4'd10, fips_rk[10]);

        // Reset at cycle 9 of an expansion.
        key_in    = '0;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        for (int c = 1; c <= 8; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_out = '0;
        chk("abort_kv", {127'd0, keys_valid}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_ready", {127'd0, key_ready}, 128'd1);
        chk("abort_out", rk_out, 128'd0);
        rd_bad("abort_rd", 4'd0);

        load_key(128'd0, 1'b0, 1'b0);
        rd_ok(4'd0, 128'd0);
        rd_ok(4'd1, zero_rk1);
        rd_ok(4'd10, zero_rk10);

        // Reload in DONE while reading idx 10 at the same edge: old key returned.
        key_in    = fips_rk[0];
        key_valid = 1'b1;
        rk_req    = 1'b1;
        rk_idx    = 4'd10;
        step();
        key_valid = 1'b0;
        rk_req    = 1'b0;
        chk("race_valid", {127'd0, rk_valid}, 128'd1);
        chk("race_out", rk_out, zero_rk10);
        chk("race_kv", {127'd0, keys_valid}, 128'd0);
        chk("race_busy", {127'd0, busy}, 128'd1);
        exp_out = zero_rk10;
        for (int c = 1; c <= 20; c++) step();
        chk("race_kv20", {127'd0, keys_valid}, 128'd1);
        rd_ok(4'd10, fips_rk[10]);
        rd_ok(4'd0, fips_rk[0]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
